fl_distributor_sel: RTL and testbench

//  FrameLink 1->N frame distributor, parametrised successor of the fixed round-robin FL distributor.
//  - Routes whole frames from one RX FrameLink to one of OUTPUT_COUNT TX FrameLinks.
//  - Output choice per frame, selected at run time: round-robin, or an index field in the first data word.
//  - Frames addressed to a non-existent output are dropped and counted.
//  - Sits between an RX MAC/buffer and per-channel processing pipelines.

---
 rtl/fl_distributor_sel.sv | 154 +++++++++++++++
 tb/tb_fl_distributor_sel.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fl_distributor_sel.sv
// FrameLink 1->N frame distributor with run-time choice of round-robin or header-index output selection.
// Optional per-output forwarded-frame counters are built when FL_DIST_FRAME_CNT_EN is defined.
module fl_distributor_sel #(
  parameter int DATA_WIDTH   = 64,
  parameter int DREM_WIDTH   = 3,
  parameter int OUTPUT_COUNT = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             MODE,
  input  logic [DATA_WIDTH-1:0]            RX_DATA,
  input  logic [DREM_WIDTH-1:0]            RX_REM,
  input  logic                             RX_SOF_N,
  input  logic                             RX_SOP_N,
  input  logic                             RX_EOP_N,
  input  logic                             RX_EOF_N,
  input  logic                             RX_SRC_RDY_N,
  output logic                             RX_DST_RDY_N,
  output logic [OUTPUT_COUNT*DATA_WIDTH-1:0] TX_DATA,
  output logic [OUTPUT_COUNT*DREM_WIDTH-1:0] TX_REM,
  output logic [OUTPUT_COUNT-1:0]          TX_SOF_N,
  output logic [OUTPUT_COUNT-1:0]          TX_SOP_N,
  output logic [OUTPUT_COUNT-1:0]          TX_EOP_N,
  output logic [OUTPUT_COUNT-1:0]          TX_EOF_N,
  output logic [OUTPUT_COUNT-1:0]          TX_SRC_RDY_N,
  input  logic [OUTPUT_COUNT-1:0]          TX_DST_RDY_N,
  output logic [CNT_WIDTH-1:0]             DROP_CNT,
  output logic [OUTPUT_COUNT*CNT_WIDTH-1:0] FRAME_CNT
);

  localparam int                   SEL_SPAN  = 2**SEL_WIDTH;
  localparam logic [SEL_WIDTH:0]   SEL_LIMIT = (SEL_WIDTH+1)'(OUTPUT_COUNT);
  localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_WIDTH'(OUTPUT_COUNT-1);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_DROP} state_t;

  state_t                state_reg, state_next;
  logic [SEL_WIDTH-1:0]  sel_reg, rr_ptr_reg, sel_cur;
  logic                  mode_reg, frame_mode;
  logic                  sel_ok, route_en, xfer;
  logic                  fwd_start, fwd_eof, drop_eof;
  logic [SEL_SPAN-1:0]   dst_rdy_pad_n;
  logic [CNT_WIDTH-1:0]  drop_cnt_reg;

  assign TX_DATA  = {OUTPUT_COUNT{RX_DATA}};
  assign TX_REM   = {OUTPUT_COUNT{RX_REM}};
  assign TX_SOF_N = {OUTPUT_COUNT{RX_SOF_N}};
  assign TX_SOP_N = {OUTPUT_COUNT{RX_SOP_N}};
  assign TX_EOP_N = {OUTPUT_COUNT{RX_EOP_N}};
  assign TX_EOF_N = {OUTPUT_COUNT{RX_EOF_N}};
  assign DROP_CNT = drop_cnt_reg;

  // In IDLE the target is decoded live from the presented word; afterwards it is frozen.
  always_comb begin
    sel_cur    = sel_reg;
    frame_mode = mode_reg;
    if (state_reg == S_IDLE) begin
      sel_cur    = MODE ? RX_DATA[SEL_WIDTH-1:0] : rr_ptr_reg;
      frame_mode = MODE;
    end
  end

  assign sel_ok   = {1'b0, sel_cur} < SEL_LIMIT;
  assign route_en = RESET && ((state_reg == S_FWD) ||
                              (state_reg == S_IDLE && !RX_SOF_N && sel_ok));

  // Unused index slots read as "not ready" so an out-of-range select never reaches a real port.
  genvar gi;
  generate
    for (gi = 0; gi < SEL_SPAN; gi++) begin : g_dst_pad
      if (gi < OUTPUT_COUNT) begin : g_real
        assign dst_rdy_pad_n[gi] = TX_DST_RDY_N[gi];
      end else begin : g_none
        assign dst_rdy_pad_n[gi] = 1'b1;
      end
    end
    for (gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_tx_rdy
      assign TX_SRC_RDY_N[gi] = !(route_en && sel_cur == SEL_WIDTH'(gi)) || RX_SRC_RDY_N;
    end
  endgenerate

  assign RX_DST_RDY_N = !RESET ? 1'b1 : (route_en ? dst_rdy_pad_n[sel_cur] : 1'b0);
  assign xfer         = !RX_SRC_RDY_N && !RX_DST_RDY_N;

  always_comb begin
    state_next = state_reg;
    fwd_start  = 1'b0;
    fwd_eof    = 1'b0;
    drop_eof   = 1'b0;
    if (xfer) begin
      case (state_reg)
        S_IDLE: begin
          if (!RX_SOF_N) begin
            if (sel_ok) begin
              if (!RX_EOF_N) fwd_eof = 1'b1;
              else begin
                fwd_start  = 1'b1;
                state_next = S_FWD;
              end
            end else if (!RX_EOF_N) drop_eof = 1'b1;
            else state_next = S_DROP;
          end
        end
        S_FWD: if (!RX_EOF_N) begin
          fwd_eof    = 1'b1;
          state_next = S_IDLE;
        end
        S_DROP: if (!RX_EOF_N) begin
          drop_eof   = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= S_IDLE;
      sel_reg      <= '0;
      mode_reg     <= 1'b0;
      rr_ptr_reg   <= '0;
      drop_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (fwd_start) begin
        sel_reg  <= sel_cur;
        mode_reg <= MODE;
      end
      if (fwd_eof && !frame_mode)
        rr_ptr_reg <= (rr_ptr_reg == SEL_LAST) ? '0 : rr_ptr_reg + 1'b1;
      if (drop_eof)
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

`ifdef FL_DIST_FRAME_CNT_EN
  generate
    for (gi = 0; gi < OUTPUT_COUNT; gi++) begin : g_frame_cnt
      logic [CNT_WIDTH-1:0] frame_cnt_reg;
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) frame_cnt_reg <= '0;
        else if (fwd_eof && sel_cur == SEL_WIDTH'(gi)) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
      assign FRAME_CNT[gi*CNT_WIDTH +: CNT_WIDTH] = frame_cnt_reg;
    end
  endgenerate
`else
  assign FRAME_CNT = '0;
`endif

endmodule

// File: tb/tb_fl_distributor_sel.sv
// Randomized bench for fl_distributor_sel: a 4-output and a 3-output instance share one RX stream
// and are compared every cycle against a word-level routing model.
module tb_fl_distributor_sel;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int CW = 32;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, mode, sof_n, sop_n, eop_n, eof_n, src_rdy_n;
  logic [DW-1:0] rx_data;
  logic [RW-1:0] rx_rem;

  logic          rx_dst4;
  logic [4*DW-1:0] tx_data4;
  logic [4*RW-1:0] tx_rem4;
  logic [3:0]    tx_sof4, tx_sop4, tx_eop4, tx_eof4, tx_src4, tx_dst4;
  logic [CW-1:0] drop4;
  logic [4*CW-1:0] fcnt4;

  logic          rx_dst3;
  logic [3*DW-1:0] tx_data3;
  logic [3*RW-1:0] tx_rem3;
  logic [2:0]    tx_sof3, tx_sop3, tx_eop3, tx_eof3, tx_src3, tx_dst3;
  logic [CW-1:0] drop3;
  logic [3*CW-1:0] fcnt3;

  fl_distributor_sel #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .OUTPUT_COUNT(4), .SEL_WIDTH(2), .CNT_WIDTH(CW)) u_dut4 (
    .CLK(clk), .RESET(rst_n), .MODE(mode), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_SOP_N(sop_n), .RX_EOP_N(eop_n), .RX_EOF_N(eof_n),
    .RX_SRC_RDY_N(src_rdy_n), .RX_DST_RDY_N(rx_dst4),
    .TX_DATA(tx_data4), .TX_REM(tx_rem4), .TX_SOF_N(tx_sof4), .TX_SOP_N(tx_sop4),
    .TX_EOP_N(tx_eop4), .TX_EOF_N(tx_eof4), .TX_SRC_RDY_N(tx_src4), .TX_DST_RDY_N(tx_dst4),
    .DROP_CNT(drop4), .FRAME_CNT(fcnt4));

  fl_distributor_sel #(.DATA_WIDTH(DW), .DREM_WIDTH(RW), .OUTPUT_COUNT(3), .SEL_WIDTH(2), .CNT_WIDTH(CW)) u_dut3 (
    .CLK(clk), .RESET(rst_n), .MODE(mode), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(sof_n), .RX_SOP_N(sop_n), .RX_EOP_N(eop_n), .RX_EOF_N(eof_n),
    .RX_SRC_RDY_N(src_rdy_n), .RX_DST_RDY_N(rx_dst3),
    .TX_DATA(tx_data3), .TX_REM(tx_rem3), .TX_SOF_N(tx_sof3), .TX_SOP_N(tx_sop3),
    .TX_EOP_N(tx_eop3), .TX_EOF_N(tx_eof3), .TX_SRC_RDY_N(tx_src3), .TX_DST_RDY_N(tx_dst3),
    .DROP_CNT(drop3), .FRAME_CNT(fcnt3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: tgt = -1 between frames, -2 discarding a bad-index frame, else the output owning the frame.
  int          oc[2] = '{4, 3};
  int          tgt[2], tmode[2], rr[2], route_c[2];
  int unsigned dcnt[2];
  int unsigned fcnt[2][4];
  logic        exp_dst[2];
  logic [3:0]  exp_src[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      tgt[k] = -1; tmode[k] = 0; rr[k] = 0; dcnt[k] = 0;
      for (int i = 0; i < 4; i++) fcnt[k][i] = 0;
    end
  endtask

  task automatic model_eval(input int k, input logic [3:0] dst_n);
    int s;
    exp_src[k] = 4'hF;
    exp_dst[k] = 1'b1;
    route_c[k] = -1;
    if (rst_n) begin
      if (tgt[k] >= 0) route_c[k] = tgt[k];
      else if (tgt[k] == -1 && !sof_n) begin
        s = mode ? int'(rx_data[1:0]) : rr[k];
        if (s < oc[k]) route_c[k] = s;
      end
      if (route_c[k] >= 0) begin
        exp_dst[k] = dst_n[route_c[k]];
        exp_src[k][route_c[k]] = src_rdy_n;
      end else exp_dst[k] = 1'b0;
    end
  endtask

  task automatic finish_frame(input int k, input int o, input int m);
`ifdef FL_DIST_FRAME_CNT_EN
    fcnt[k][o]++;
`endif
    if (m == 0) rr[k] = (rr[k] + 1) % oc[k];
  endtask

  task automatic model_step(input int k);
    if (!rst_n || src_rdy_n || exp_dst[k]) return;
    if (tgt[k] == -1) begin
      if (!sof_n) begin
        if (route_c[k] >= 0) begin
          if (!eof_n) finish_frame(k, route_c[k], int'(mode));
          else begin tgt[k] = route_c[k]; tmode[k] = int'(mode); end
        end else begin
          if (!eof_n) dcnt[k]++;
          else tgt[k] = -2;
        end
      end
    end else if (tgt[k] >= 0) begin
      if (!eof_n) begin finish_frame(k, tgt[k], tmode[k]); tgt[k] = -1; end
    end else if (!eof_n) begin
      dcnt[k]++;
      tgt[k] = -1;
    end
  endtask

  task automatic check_dut(input int k, input int cyc);
    logic [255:0] g_data, e_data, g_rem, e_rem, g_fr, e_fr, g_fc, e_fc;
    logic         g_dst;
    logic [3:0]   g_src;
    logic [CW-1:0] g_drop;
    g_data = '0; e_data = '0; g_rem = '0; e_rem = '0;
    g_fr = '0; e_fr = '0; g_fc = '0; e_fc = '0;
    if (k == 0) begin
      g_dst = rx_dst4; g_src = tx_src4; g_drop = drop4;
      g_data = 256'(tx_data4); g_rem = 256'(tx_rem4); g_fc = 256'(fcnt4);
      for (int i = 0; i < 4; i++) g_fr[i*4 +: 4] = {tx_sof4[i], tx_sop4[i], tx_eop4[i], tx_eof4[i]};
    end else begin
      g_dst = rx_dst3; g_src = {1'b1, tx_src3}; g_drop = drop3;
      g_data = 256'(tx_data3); g_rem = 256'(tx_rem3); g_fc = 256'(fcnt3);
      for (int i = 0; i < 3; i++) g_fr[i*4 +: 4] = {tx_sof3[i], tx_sop3[i], tx_eop3[i], tx_eof3[i]};
    end
    for (int i = 0; i < oc[k]; i++) begin
      e_data[i*DW +: DW] = rx_data;
      e_rem[i*RW +: RW]  = rx_rem;
      e_fr[i*4 +: 4]     = {sof_n, sop_n, eop_n, eof_n};
      e_fc[i*CW +: CW]   = fcnt[k][i];
    end
    check_val($sformatf("oc%0d rx_dst_rdy_n cyc%0d", oc[k], cyc), 256'(g_dst), 256'(exp_dst[k]));
    check_val($sformatf("oc%0d tx_src_rdy_n cyc%0d", oc[k], cyc), 256'(g_src), 256'(exp_src[k]));
    check_val($sformatf("oc%0d drop_cnt cyc%0d", oc[k], cyc), 256'(g_drop), 256'(dcnt[k]));
    check_val($sformatf("oc%0d frame_cnt cyc%0d", oc[k], cyc), g_fc, e_fc);
    check_val($sformatf("oc%0d tx_data cyc%0d", oc[k], cyc), g_data, e_data);
    check_val($sformatf("oc%0d tx_rem cyc%0d", oc[k], cyc), g_rem, e_rem);
    check_val($sformatf("oc%0d tx_framing cyc%0d", oc[k], cyc), g_fr, e_fr);
  endtask

  int flen, widx, rst_hold;
  bit need_word, adv;

  task automatic gen_word();
    if (widx >= flen) begin
      if ($urandom_range(0, 9) == 0) begin
        sof_n = 1'b1; sop_n = 1'b1;
        eof_n = 1'($urandom_range(0, 1)); eop_n = eof_n;
        rx_data = {$urandom, $urandom}; rx_rem = 3'($urandom_range(0, 7));
        return;
      end
      flen = $urandom_range(1, 5);
      widx = 0;
    end
    sof_n = !(widx == 0);
    eof_n = !(widx == flen - 1);
    sop_n = sof_n;
    eop_n = eof_n;
    rx_data = {$urandom, $urandom};
    rx_rem = 3'($urandom_range(0, 7));
    widx++;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; src_rdy_n = 1'b1;
    sof_n = 1'b1; sop_n = 1'b1; eop_n = 1'b1; eof_n = 1'b1;
    rx_data = '0; rx_rem = '0; tx_dst4 = '0; tx_dst3 = '0;
    flen = 0; widx = 0; rst_hold = 0; need_word = 1'b1; adv = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 3) rst_n = 1'b0;
      else if (rst_hold > 0) begin rst_hold--; rst_n = 1'b0; end
      else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 299) == 0) begin
          rst_n = 1'b0; rst_hold = 1; need_word = 1'b1; widx = flen;
        end
      end
      if (adv) need_word = 1'b1;
      if (need_word) begin gen_word(); need_word = 1'b0; end
      mode = 1'($urandom_range(0, 1));
      src_rdy_n = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < 4; i++) tx_dst4[i] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) tx_dst3[i] = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (!rst_n) model_reset();
      model_eval(0, tx_dst4);
      model_eval(1, {1'b1, tx_dst3});
      check_dut(0, cyc);
      check_dut(1, cyc);
      adv = rst_n && !src_rdy_n && !exp_dst[0];
      model_step(0);
      model_step(1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
